// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv : iterative RV32M multiply/divide unit for the execute stage.
//
// Performs MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on operand
// magnitudes with one shift-add (multiply) or restoring-subtract (divide)
// step per cycle, then applies sign correction. Divide-by-zero and signed
// overflow finish in a single cycle with the RISC-V defined results.
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN - multiplies use a single-cycle XLENxXLEN multiplier
//                        (start -> MUL -> DONE); the divide path is unchanged.
//
// Ports:
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     M-extension instruction present in EX
//   funct3  in   3     operation select (000 MUL .. 111 REMU)
//   src_a   in   XLEN  rs1 value
//   src_b   in   XLEN  rs2 value
//   flush   in   1     synchronous kill of the in-flight operation
//   stall   out  1     hold IF/ID/EX while the unit is busy
//   done    out  1     result valid this cycle
//   result  out  XLEN  product half, quotient or remainder
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negate when en is set (double width and single width).
    function automatic logic [2*XLEN-1:0] neg_w(input logic [2*XLEN-1:0] v, input logic en);
        if (en) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
        if (en) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    state_t            state_r, state_nxt_s;
    logic [2:0]        funct3_r;
    logic [XLEN-1:0]   ma_r, mb_r, acc_r, lo_r, result_r;
    logic [CNT_W-1:0]  count_r;
    logic              neg_q_r, neg_rem_r;

    logic              a_signed_s, b_signed_s, sa_s, sb_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_res_s;
    logic              div_zero_s, ovf_s, special_s, accept_s, busy_s, last_s;
    logic              mul_last_s, div_last_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0]   acc_step_s, lo_step_s;
    logic [2*XLEN-1:0] prod_raw_s, prod_fix_s;
    logic [XLEN-1:0]   mul_res_s, quo_fix_s, rem_fix_s, final_res_s;

    // Operand signedness per funct3 (MULHSU: rs1 signed, rs2 unsigned).
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign sa_s       = a_signed_s & src_a[XLEN-1];
    assign sb_s       = b_signed_s & src_b[XLEN-1];
    assign mag_a_s    = neg_x(src_a, sa_s);
    assign mag_b_s    = neg_x(src_b, sb_s);
    assign div_zero_s = funct3[2] & (src_b == ZERO);
    assign ovf_s      = funct3[2] & ~funct3[0] & (src_a == MIN_VAL) & (src_b == ONES);
    assign special_s  = div_zero_s | ovf_s;
    assign accept_s   = (state_r == S_IDLE) & start & ~flush;
    assign busy_s     = (state_r == S_MUL) | (state_r == S_DIV);

    // Single-cycle results for x/0 and MIN/-1 (remainder ops select the rem value).
    always_comb begin
        special_res_s = ZERO;
        if (div_zero_s) begin
            special_res_s = funct3[1] ? src_a : ONES;
        end else if (ovf_s) begin
            special_res_s = funct3[1] ? ZERO : MIN_VAL;
        end else begin
            special_res_s = ZERO;
        end
    end

    // acc holds the product high half / partial remainder; lo holds the
    // multiplier bits being consumed / dividend bits becoming the quotient.
    assign mul_sum_s   = {1'b0, acc_r} + {1'b0, (lo_r[0] ? ma_r : ZERO)};
    assign div_shift_s = {acc_r, lo_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, mb_r};

    // One iteration step for the current state.
    always_comb begin
        acc_step_s = acc_r;
        lo_step_s  = lo_r;
        if (state_r == S_MUL) begin
            acc_step_s = mul_sum_s[XLEN:1];
            lo_step_s  = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end else if (state_r == S_DIV) begin
            if (!div_diff_s[XLEN]) begin
                acc_step_s = div_diff_s[XLEN-1:0];
                lo_step_s  = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                acc_step_s = div_shift_s[XLEN-1:0];
                lo_step_s  = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step_s = acc_r;
            lo_step_s  = lo_r;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign prod_raw_s = {{XLEN{1'b0}}, ma_r} * {{XLEN{1'b0}}, mb_r};
    assign mul_last_s = 1'b1;
`else
    assign prod_raw_s = {acc_step_s, lo_step_s};
    assign mul_last_s = (count_r == LAST_CNT);
`endif
    assign div_last_s = (count_r == LAST_CNT);
    assign last_s     = ((state_r == S_MUL) & mul_last_s) | ((state_r == S_DIV) & div_last_s);

    // Sign correction and result selection, taken from the final step's values.
    always_comb begin
        prod_fix_s  = neg_w(prod_raw_s, neg_q_r);
        quo_fix_s   = neg_x(lo_step_s, neg_q_r);
        rem_fix_s   = neg_x(acc_step_s, neg_rem_r);
        mul_res_s   = (funct3_r[1:0] == 2'b00) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        if (funct3_r[2]) begin
            final_res_s = funct3_r[1] ? rem_fix_s : quo_fix_s;
        end else begin
            final_res_s = mul_res_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush returns to IDLE from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        if (special_s) begin
                            state_nxt_s = S_DONE;
                        end else begin
                            state_nxt_s = funct3[2] ? S_DIV : S_MUL;
                        end
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_MUL:   state_nxt_s = mul_last_s ? S_DONE : S_MUL;
                S_DIV:   state_nxt_s = div_last_s ? S_DONE : S_DIV;
                S_DONE:  state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // FSM outputs: stall covers the accept cycle and all iteration cycles.
    always_comb begin
        stall = accept_s | busy_s;
        done  = (state_r == S_DONE) & ~flush;
    end

    assign result = result_r;

    // Datapath: latch operands on accept, iterate while busy, capture result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_r  <= 3'b000;
            ma_r      <= ZERO;
            mb_r      <= ZERO;
            acc_r     <= ZERO;
            lo_r      <= ZERO;
            count_r   <= {CNT_W{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= ZERO;
        end else if (accept_s) begin
            funct3_r  <= funct3;
            ma_r      <= mag_a_s;
            mb_r      <= mag_b_s;
            acc_r     <= ZERO;
            lo_r      <= funct3[2] ? mag_a_s : mag_b_s;
            count_r   <= {CNT_W{1'b0}};
            neg_q_r   <= sa_s ^ sb_s;
            neg_rem_r <= sa_s;
            if (special_s) begin
                result_r <= special_res_s;
            end
        end else if (busy_s && !flush) begin
            acc_r   <= acc_step_s;
            lo_r    <= lo_step_s;
            count_r <= count_r + CNT_W'(1);
            if (last_s) begin
                result_r <= final_res_s;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv : self-checking bench for ex_muldiv.
// Directed RV32M cases plus random operations are compared against an
// arithmetic reference model; latency, stall, flush and reset are checked.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

    localparam logic [31:0] MIN32  = 32'h8000_0000;
    localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        stall, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: RISC-V M semantics via 64-bit / 32-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'h0, b});
        logic [63:0] p;
        int          ia = $signed(a);
        int          ib = $signed(b);
        int          q;
        logic [31:0] r;
        case (f)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 32'h0)                    r = ONES32;
                else if (a == MIN32 && b == ONES32) r = MIN32;
                else begin q = ia / ib; r = q; end
            end
            3'd5: r = (b == 32'h0) ? ONES32 : a / b;
            3'd6: begin
                if (b == 32'h0)                    r = a;
                else if (a == MIN32 && b == ONES32) r = 32'h0;
                else begin q = ia % ib; r = q; end
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'h0 || (!f[0] && a == MIN32 && b == ONES32))) return 1;
        else if (f[2]) return DIV_LAT;
        else return MUL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        int unsigned k = $urandom_range(0, 7);
        case (k)
            0: return 32'h0;
            1: return MIN32;
            2: return ONES32;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation (caller is just after a rising edge), hold start
    // while stalled, scramble inputs after acceptance, check latency/stall/result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp_res = ref_model(f, a, b);
        int          exp_lat = ref_latency(f, a, b);
        int          lat = -1;
        int          stall_low = 0;
        int          c = 0;
        logic        stall_at_done = 1'b1;
        funct3 = f; src_a = a; src_b = b; start = 1'b1;
        while (lat < 0 && c < 100) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                stall_at_done = stall;
            end else begin
                if (stall !== 1'b1) stall_low++;
                @(posedge clk); #1;
                funct3 = 3'($urandom_range(0, 7));
                src_a  = $urandom;
                src_b  = $urandom;
                c++;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_busy"}, 32'(stall_low), 32'd0);
        check({tag, "_stall_done"}, {31'h0, stall_at_done}, 32'h0);
        check({tag, "_result"}, result, exp_res);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int not_done;

        // Reset state
        #7;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed arithmetic cases (issued back-to-back)
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        run_op(3'b011, ONES32, ONES32, "mulhu_ones");
        run_op(3'b010, ONES32, 32'd2, "mulhsu_m1_2");
        run_op(3'b001, MIN32, MIN32, "mulh_min_min");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(3'b101, 32'd100, 32'd7, "divu_100_7");
        run_op(3'b111, 32'd100, 32'd7, "remu_100_7");
        run_op(3'b100, 32'd5, 32'd0, "div_5_0");
        run_op(3'b110, 32'd5, 32'd0, "rem_5_0");
        run_op(3'b101, 32'd5, 32'd0, "divu_5_0");
        run_op(3'b111, 32'd5, 32'd0, "remu_5_0");
        run_op(3'b100, MIN32, ONES32, "div_ovf");
        run_op(3'b110, MIN32, ONES32, "rem_ovf");
        run_op(3'b111, MIN32, ONES32, "remu_min_m1");

        // Random operations with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), "rand");
        end

        // Flush on cycle 10 of a DIV: no done, stall drops, next op completes
        funct3 = 3'b100; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
        not_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) not_done++;
            @(posedge clk); #1;
        end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        check("flush_div_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_div_stall_after", {31'h0, stall}, 32'h0);
        check("flush_div_done_after", {31'h0, done}, 32'h0);
        check("flush_div_no_done_before", 32'(not_done), 32'd0);
        @(posedge clk); #1;
        run_op(3'b110, 32'hFFFF_FF38, 32'd7, "after_flush_rem");

        // flush together with start in IDLE: nothing is latched
        funct3 = 3'b100; src_a = 32'd9; src_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_stall_next", {31'h0, stall}, 32'h0);
        check("flush_idle_done_next", {31'h0, done}, 32'h0);
        @(posedge clk); #1;

        // flush in the DONE cycle forces done low
        funct3 = 3'b100; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_done_cycle", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_done_stall_next", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a DIV
        run_op(3'b101, 32'd12345, 32'd10, "pre_reset_divu");
        funct3 = 3'b100; src_a = 32'd77; src_b = 32'd5; start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        check("midrst_stall", {31'h0, stall}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_result", result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(3'b000, 32'd12, 32'hFFFF_FFF6, "post_rst_mul1");
        run_op(3'b001, 32'h1234_5678, 32'h8765_4321, "post_rst_mul2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
